// File: rtl/hardware_transmitter.sv
// Serial line transmitter: start bit, MSB-first payload, optional even parity, stop bits.
// Define HW_TX_PARITY_EN to insert a one-bit-period parity slot between payload and stop.
module hardware_transmitter #(
    parameter int DATA_WIDTH      = 8,
    parameter int SAMPLES_PER_BIT = 10,
    parameter int STOP_BITS       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic                  dout,
    output logic                  busy
);

    localparam int CNT_W = $clog2(SAMPLES_PER_BIT);
    localparam int BIT_W = $clog2(DATA_WIDTH + STOP_BITS + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef HW_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SAMPLES_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  dout_q, dout_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
`ifdef HW_TX_PARITY_EN
    logic                  parity_q, parity_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        dout_d   = dout_q;
        busy_d   = busy_q;
        ready_d  = ready_q;
`ifdef HW_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q == ST_IDLE) begin
            // Outputs are registered on the accept edge so the start bit begins immediately.
            if (din_valid && ready_q) begin
                state_d  = ST_START;
                cnt_d    = '0;
                bit_d    = '0;
                shift_d  = din_data;
                dout_d   = 1'b1;
                busy_d   = 1'b1;
                ready_d  = 1'b0;
`ifdef HW_TX_PARITY_EN
                parity_d = ^din_data;
`endif
            end else begin
                dout_d  = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
            case (state_q)
                ST_START: begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    dout_d  = shift_q[DATA_WIDTH-1];
                    shift_d = shift_q << 1;
                end
                ST_DATA: begin
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
`ifdef HW_TX_PARITY_EN
                        state_d = ST_PARITY;
                        dout_d  = parity_q;
`else
                        state_d = ST_STOP;
                        dout_d  = 1'b0;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        dout_d  = shift_q[DATA_WIDTH-1];
                        shift_d = shift_q << 1;
                    end
                end
`ifdef HW_TX_PARITY_EN
                ST_PARITY: begin
                    state_d = ST_STOP;
                    bit_d   = '0;
                    dout_d  = 1'b0;
                end
`endif
                ST_STOP: begin
                    if (bit_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        bit_d   = '0;
                        dout_d  = 1'b0;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    dout_d  = 1'b0;
                    busy_d  = 1'b0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            dout_q   <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
`ifdef HW_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            dout_q   <= dout_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
`ifdef HW_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign busy      = busy_q;
    assign din_ready = ready_q;

endmodule
